// File: rtl/exc_pkg.sv
// Shared definitions for the exception/interrupt sequencer: cause codes,
// CP0 STATUS field positions and controller state encoding.
package exc_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IM_LSB = 11;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ENTER    = 2'd1,
        S_VEC      = 2'd2,
        S_ERET_RED = 2'd3
    } exc_state_e;

    // A delay-slot instruction restarts at its branch so the branch re-executes.
    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
        return bd ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/exc_prio.sv
// Combinational priority encoder choosing which interrupt/exception, if any,
// the MEM-stage instruction takes, and whether EPC/CAUSE should be captured.
module exc_prio
    import exc_pkg::*;
(
    input  logic       mem_valid,
    input  logic       exl,
    input  logic       int_take,
    input  logic [5:0] exc_req,
    input  logic       exc_ades,
    output logic       take,
    output logic [4:0] exccode,
    output logic       epc_we
);

    // Highest-priority cause wins; only fetch errors and RI survive EXL=1.
    always_comb begin
        take    = 1'b0;
        exccode = EXC_INT;
        epc_we  = 1'b0;
        if (!mem_valid) begin
            take = 1'b0;
        end else if (int_take) begin
            take    = 1'b1;
            exccode = EXC_INT;
            epc_we  = 1'b1;
        end else if (exc_req[5]) begin
            take    = 1'b1;
            exccode = EXC_ADEL;
            epc_we  = ~exl;
        end else if (exc_req[4]) begin
            take    = 1'b1;
            exccode = EXC_RI;
            epc_we  = ~exl;
        end else if (exl) begin
            take = 1'b0;
        end else if (exc_req[3]) begin
            take    = 1'b1;
            exccode = EXC_OV;
            epc_we  = 1'b1;
        end else if (exc_req[2]) begin
            take    = 1'b1;
            exccode = EXC_SYS;
            epc_we  = 1'b1;
        end else if (exc_req[1]) begin
            take    = 1'b1;
            exccode = EXC_BP;
            epc_we  = 1'b1;
        end else if (exc_req[0]) begin
            take    = 1'b1;
            exccode = exc_ades ? EXC_ADES : EXC_ADEL;
            epc_we  = 1'b1;
        end else begin
            take = 1'b0;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: accepts a cause from MEM, updates CP0, flushes
// the pipeline and redirects fetch to the handler or to EPC on ERET.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0380,
    parameter int          INT_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid,
    input  logic [31:0]      mem_pc,
    input  logic             mem_bd,
    input  logic [5:0]       exc_req,
    input  logic             exc_ades,
    input  logic             eret,
    input  logic [INT_W-1:0] int_pend,
    input  logic [31:0]      status_in,
    input  logic [31:0]      epc_in,
    output logic             cp0_exl,
    output logic             cp0_bd,
    output logic [4:0]       cp0_exccode,
    output logic [31:0]      cp0_epc,
    output logic             cp0_epc_we,
    output logic             flush,
    output logic             redir_valid,
    output logic [31:0]      redir_pc,
    input  logic             redir_ready,
    output logic             busy
);

    exc_state_e  state_q, state_d;
    logic        exl_q, exl_d;
    logic        bd_q, bd_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [31:0] epc_q, epc_d;
    logic        epc_we_q, epc_we_d;
    logic        flush_q, flush_d;
    logic        redir_valid_q, redir_valid_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic        busy_q, busy_d;

    logic        int_take_s;
    logic        take_s;
    logic [4:0]  prio_code_s;
    logic        prio_we_s;
    logic        unused_status_s;

    assign unused_status_s = ^status_in;

    assign int_take_s = mem_valid & status_in[STATUS_IE] & ~status_in[STATUS_EXL]
                      & (|(int_pend & status_in[STATUS_IM_LSB +: INT_W]));

    exc_prio u_prio (
        .mem_valid (mem_valid),
        .exl       (status_in[STATUS_EXL]),
        .int_take  (int_take_s),
        .exc_req   (exc_req),
        .exc_ades  (exc_ades),
        .take      (take_s),
        .exccode   (prio_code_s),
        .epc_we    (prio_we_s)
    );

    // Next-state and next-output logic; outputs are derived from the next state
    // so every port comes straight from a flop.
    always_comb begin
        state_d    = state_q;
        exl_d      = exl_q;
        bd_d       = bd_q;
        exccode_d  = exccode_q;
        epc_d      = epc_q;
        epc_we_d   = 1'b0;
        redir_pc_d = redir_pc_q;
        case (state_q)
            S_IDLE: begin
                exl_d      = status_in[STATUS_EXL];
                redir_pc_d = 32'd0;
                if (take_s) begin
                    state_d   = S_ENTER;
                    bd_d      = mem_bd;
                    exccode_d = prio_code_s;
                    epc_d     = epc_of(mem_pc, mem_bd);
                    epc_we_d  = prio_we_s;
                    exl_d     = 1'b1;
                end else if (mem_valid && eret) begin
                    state_d    = S_ERET_RED;
                    redir_pc_d = epc_in;
                    exl_d      = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ENTER: begin
                state_d    = S_VEC;
                redir_pc_d = EXC_VECTOR;
                exl_d      = 1'b1;
            end
            S_VEC, S_ERET_RED: begin
                if (redir_ready) begin
                    state_d    = S_IDLE;
                    redir_pc_d = 32'd0;
                    exl_d      = status_in[STATUS_EXL];
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d    = S_IDLE;
                redir_pc_d = 32'd0;
                exl_d      = 1'b0;
            end
        endcase
        flush_d       = (state_d != S_IDLE);
        busy_d        = (state_d != S_IDLE);
        redir_valid_d = (state_d == S_VEC) || (state_d == S_ERET_RED);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            exl_q         <= 1'b0;
            bd_q          <= 1'b0;
            exccode_q     <= 5'd0;
            epc_q         <= 32'd0;
            epc_we_q      <= 1'b0;
            flush_q       <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= 32'd0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            exl_q         <= exl_d;
            bd_q          <= bd_d;
            exccode_q     <= exccode_d;
            epc_q         <= epc_d;
            epc_we_q      <= epc_we_d;
            flush_q       <= flush_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            busy_q        <= busy_d;
        end
    end

    assign cp0_exl     = exl_q;
    assign cp0_bd      = bd_q;
    assign cp0_exccode = exccode_q;
    assign cp0_epc     = epc_q;
    assign cp0_epc_we  = epc_we_q;
    assign flush       = flush_q;
    assign redir_valid = redir_valid_q;
    assign redir_pc    = redir_pc_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed self-checking bench for exc_ctrl with hand-computed expectations.
module tb_exc_ctrl;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_bd;
    logic [5:0]  exc_req;
    logic        exc_ades;
    logic        eret;
    logic [4:0]  int_pend;
    logic [31:0] status_in;
    logic [31:0] epc_in;
    logic        cp0_exl;
    logic        cp0_bd;
    logic [4:0]  cp0_exccode;
    logic [31:0] cp0_epc;
    logic        cp0_epc_we;
    logic        flush;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        redir_ready;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    exc_ctrl #(.EXC_VECTOR(32'h0000_0380), .INT_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_valid   (mem_valid),
        .mem_pc      (mem_pc),
        .mem_bd      (mem_bd),
        .exc_req     (exc_req),
        .exc_ades    (exc_ades),
        .eret        (eret),
        .int_pend    (int_pend),
        .status_in   (status_in),
        .epc_in      (epc_in),
        .cp0_exl     (cp0_exl),
        .cp0_bd      (cp0_bd),
        .cp0_exccode (cp0_exccode),
        .cp0_epc     (cp0_epc),
        .cp0_epc_we  (cp0_epc_we),
        .flush       (flush),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .redir_ready (redir_ready),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_req();
        mem_valid = 1'b0;
        mem_bd    = 1'b0;
        exc_req   = 6'd0;
        exc_ades  = 1'b0;
        eret      = 1'b0;
        int_pend  = 5'd0;
    endtask

    initial begin
        rst         = 1'b0;
        mem_pc      = 32'd0;
        status_in   = 32'h0000_0001;
        epc_in      = 32'd0;
        redir_ready = 1'b0;
        clr_req();
        step();
        step();
        check_eq("rst_busy",   {31'd0, busy},        32'd0);
        check_eq("rst_rvalid", {31'd0, redir_valid}, 32'd0);
        check_eq("rst_rpc",    redir_pc,             32'd0);
        check_eq("rst_epc",    cp0_epc,              32'd0);
        check_eq("rst_exl",    {31'd0, cp0_exl},     32'd0);
        rst = 1'b1;
        step();

        // Sys, not in a delay slot
        mem_valid = 1'b1; mem_pc = 32'h0000_0100; exc_req = 6'b000100;
        step();
        clr_req();
        check_eq("sys_we",    {31'd0, cp0_epc_we},  32'd1);
        check_eq("sys_code",  {27'd0, cp0_exccode}, 32'd8);
        check_eq("sys_epc",   cp0_epc,              32'h0000_0100);
        check_eq("sys_bd",    {31'd0, cp0_bd},      32'd0);
        check_eq("sys_exl",   {31'd0, cp0_exl},     32'd1);
        check_eq("sys_flush", {31'd0, flush},       32'd1);
        check_eq("sys_rv0",   {31'd0, redir_valid}, 32'd0);
        step();
        check_eq("sys_rv1",   {31'd0, redir_valid}, 32'd1);
        check_eq("sys_rpc",   redir_pc,             32'h0000_0380);
        check_eq("sys_we0",   {31'd0, cp0_epc_we},  32'd0);
        step();
        check_eq("sys_hold",  {31'd0, redir_valid}, 32'd1);
        redir_ready = 1'b1;
        step();
        redir_ready = 1'b0;
        check_eq("sys_idle",  {31'd0, busy},        32'd0);
        check_eq("sys_rvx",   {31'd0, redir_valid}, 32'd0);
        check_eq("sys_exlm",  {31'd0, cp0_exl},     32'd0);

        // Ov in a delay slot
        mem_valid = 1'b1; mem_pc = 32'h0000_0204; mem_bd = 1'b1; exc_req = 6'b001000;
        step();
        clr_req();
        check_eq("ov_epc",  cp0_epc,              32'h0000_0200);
        check_eq("ov_bd",   {31'd0, cp0_bd},      32'd1);
        check_eq("ov_code", {27'd0, cp0_exccode}, 32'd12);
        redir_ready = 1'b1;
        step();
        check_eq("ov_rv",   {31'd0, redir_valid}, 32'd1);
        step();
        redir_ready = 1'b0;
        check_eq("ov_idle", {31'd0, busy},        32'd0);

        // Interrupt and Bp on the same instruction: interrupt wins
        status_in = 32'h0000_2001; int_pend = 5'b00100;
        mem_valid = 1'b1; mem_pc = 32'h0000_0300; exc_req = 6'b000010;
        step();
        clr_req();
        check_eq("int_code", {27'd0, cp0_exccode}, 32'd0);
        check_eq("int_epc",  cp0_epc,              32'h0000_0300);
        check_eq("int_we",   {31'd0, cp0_epc_we},  32'd1);
        redir_ready = 1'b1;
        step();
        step();
        redir_ready = 1'b0;
        check_eq("int_idle", {31'd0, busy},        32'd0);

        // Interrupt masked by IE=0, then by EXL=1
        status_in = 32'h0000_2000; int_pend = 5'b00100; mem_valid = 1'b1;
        step();
        check_eq("ie0_busy", {31'd0, busy}, 32'd0);
        status_in = 32'h0000_2003;
        step();
        step();
        check_eq("exl_busy", {31'd0, busy},    32'd0);
        check_eq("exl_mirr", {31'd0, cp0_exl}, 32'd1);
        // Sys ignored under EXL, RI still taken without EPC capture
        exc_req = 6'b000100;
        step();
        check_eq("exl_sys",  {31'd0, busy}, 32'd0);
        exc_req = 6'b010000; mem_pc = 32'h0000_0500;
        step();
        clr_req();
        check_eq("exl_ri",   {31'd0, busy},        32'd1);
        check_eq("exl_rico", {27'd0, cp0_exccode}, 32'd10);
        check_eq("exl_riwe", {31'd0, cp0_epc_we},  32'd0);
        redir_ready = 1'b1;
        step();
        status_in = 32'h0000_0001;
        step();
        redir_ready = 1'b0;
        check_eq("ri_idle",  {31'd0, busy},    32'd0);
        check_eq("ri_exl",   {31'd0, cp0_exl}, 32'd0);
        // Bubble carrying an exception flag is ignored
        exc_req = 6'b000100;
        step();
        clr_req();
        check_eq("bubble",   {31'd0, busy}, 32'd0);

        // ERET with PC mux back-pressure; target sampled at entry
        epc_in = 32'h4000_0010; mem_valid = 1'b1; eret = 1'b1;
        step();
        clr_req();
        epc_in = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            check_eq("eret_rv",  {31'd0, redir_valid}, 32'd1);
            check_eq("eret_pc",  redir_pc,             32'h4000_0010);
            check_eq("eret_exl", {31'd0, cp0_exl},     32'd0);
            step();
        end
        redir_ready = 1'b1;
        step();
        redir_ready = 1'b0;
        check_eq("eret_idle", {31'd0, busy},        32'd0);
        check_eq("eret_rvx",  {31'd0, redir_valid}, 32'd0);

        // Reset asserted while in VEC
        mem_valid = 1'b1; mem_pc = 32'h0000_0600; exc_req = 6'b000100;
        step();
        clr_req();
        step();
        check_eq("mid_rv",   {31'd0, redir_valid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("mid_rv0",  {31'd0, redir_valid}, 32'd0);
        check_eq("mid_busy", {31'd0, busy},        32'd0);
        check_eq("mid_epc",  cp0_epc,              32'd0);
        check_eq("mid_code", {27'd0, cp0_exccode}, 32'd0);
        check_eq("mid_fl",   {31'd0, flush},       32'd0);
        check_eq("mid_exl",  {31'd0, cp0_exl},     32'd0);
        step();
        rst = 1'b1;
        mem_valid = 1'b1; mem_pc = 32'h0000_0700; exc_req = 6'b000100;
        step();
        clr_req();
        check_eq("post_we",   {31'd0, cp0_epc_we},  32'd1);
        check_eq("post_epc",  cp0_epc,              32'h0000_0700);
        check_eq("post_code", {27'd0, cp0_exccode}, 32'd8);
        redir_ready = 1'b1;
        step();
        step();
        redir_ready = 1'b0;
        check_eq("post_idle", {31'd0, busy},        32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
